mult_share_arb: RTL
===================

# mult_share_arb

Round-robin arbiter that shares one `WL`×`WL` unsigned multiplier core (`Mult_Main`/`Mult_IP`) among `NREQ` requesters. It accepts one operand pair per cycle via valid/ready handshakes and drives the multiplier inputs from a register stage. It tracks each in-flight product through a tag pipeline matched to the core latency, and returns each product to its originating requester. It sits between the operator front-ends and the single multiplier instance.

## Interface
- `WL`, 9, operand width; product width is `2*WL`.
- `NREQ`, 4, number of requesters, 2..8.
- `LAT`, 1, multiplier core latency in cycles from `mult_a`/`mult_b` change to valid `mult_p`, 0..8 (0 = combinational core).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  `NREQ`  per-requester operand valid.
- `req_a`  in  `NREQ*WL`  operand A; requester i at bits `[i*WL +: WL]`.
- `req_b`  in  `NREQ*WL`  operand B, same packing.
- `req_ready`  out  `NREQ`  grant; at most one bit high per cycle.
- `mult_a`  out  `WL`  registered operand A to core.
- `mult_b`  out  `WL`  registered operand B to core.
- `mult_p`  in  `2*WL`  core product.
- `rsp_valid`  out  `NREQ`  one-hot product-valid strobe, one cycle per product.
- `rsp_p`  out  `2*WL`  product; meaningful only while `rsp_valid` ≠ 0.
- `idle`  out  1  high when no product is in flight.

## Operation
- Arbitration: `req_ready` is combinational from `req_valid` and the priority pointer `ptr`. The first valid requester searching `ptr, ptr+1, …` modulo `NREQ` is granted. A transfer occurs when `req_valid[i] & req_ready[i]`.
- On transfer from i: `ptr <= (i+1) mod NREQ`; `mult_a/mult_b <= req_a/req_b` slice i. With no transfer, `ptr`, `mult_a` and `mult_b` hold.
- Tag pipeline: `LAT+1` stages of {valid, id[$clog2(NREQ)-1:0]}. Stage 0 loads {transfer, i} every cycle; the stages shift unconditionally. No backpressure exists: requesters must accept `rsp_valid` when it fires.
- Response: when the last stage is valid, `rsp_valid[id]=1` and `rsp_p` carries the corresponding `mult_p`. Otherwise `rsp_valid=0`.
- `idle` = no valid bit in any tag stage and no output-register valid.
- Throughput: one grant per cycle. Back-to-back grants to the same requester are allowed when it is the only one valid.
- Arithmetic: unsigned; the product is the full `2*WL` bits with no truncation, performed by the core.
- Reset (any time, including mid-operation): `ptr=0`, `mult_a=mult_b=0`, all tag valids 0, `rsp_valid=0`, `rsp_p=0`, `idle=1`. In-flight products are discarded with no response.
- `req_ready` is 0 for all requesters while `rst_n=0`.

## Timing
- Grant accepted in cycle t → `mult_a/mult_b` valid in t+1 → `mult_p` valid in t+1+`LAT`.
- Response latency is t+1+`LAT` without `MULT_ARB_OUTREG_EN`, and t+2+`LAT` with it.
- Responses are delivered in grant order, one per cycle at most.
- `req_valid` may drop without a transfer, and operands may change while not granted; only the values in the transfer cycle are used.

## Configuration
- `MULT_ARB_OUTREG_EN` defined: `rsp_valid`/`rsp_p` are registered from the last tag stage and `mult_p`. This adds one cycle of latency, makes the outputs glitch-free, and `rsp_p` holds its last value when idle.
- `MULT_ARB_OUTREG_EN` undefined: `rsp_p = mult_p` and `rsp_valid` are decoded combinationally from the last tag stage; `rsp_p` follows `mult_p` while idle.

## Test plan
- Single request, `LAT=1`, macro off: requester 2 sends A=511, B=511 at cycle t → `rsp_valid=4'b0100`, `rsp_p=261121` at t+2; `idle` returns to 1 at t+3.
- All four requesters held valid for 8 cycles → grant order 0,1,2,3,0,1,2,3. Responses arrive in the same order with products A_i×B_i, one per cycle, with no gaps.
- Requesters 1 and 3 valid, `ptr=2` → requester 3 granted first, then requester 1. `ptr` ends at 2.
- Macro on, `LAT=3`: A=7, B=9 at t → `rsp_p=63` with its strobe at t+5, and `rsp_p` still 63 at t+6.
- Reset asserted asynchronously with 3 products in flight → all outputs take reset values immediately. No `rsp_valid` pulse occurs after release, and the next grant goes to requester 0.
- Single requester valid continuously with A=1..10, B=2 → 10 consecutive grants and responses 2,4,…,20 on consecutive cycles.

Source files
------------

// File: rtl/mult_share_arb_if.sv
// Operand, multiplier-core and response signals between requesters, core and mult_share_arb.
// slave is the arbiter side; master is the requester/core side.
interface mult_share_arb_if #(
   parameter int WL   = 9,
   parameter int NREQ = 4
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*WL-1:0] req_a;
   logic [NREQ*WL-1:0] req_b;
   logic [NREQ-1:0]    req_ready;
   logic [WL-1:0]      mult_a;
   logic [WL-1:0]      mult_b;
   logic [2*WL-1:0]    mult_p;
   logic [NREQ-1:0]    rsp_valid;
   logic [2*WL-1:0]    rsp_p;
   logic               idle;

   modport slave (
      input  req_valid, req_a, req_b, mult_p,
      output req_ready, mult_a, mult_b, rsp_valid, rsp_p, idle
   );

   modport master (
      output req_valid, req_a, req_b, mult_p,
      input  req_ready, mult_a, mult_b, rsp_valid, rsp_p, idle
   );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one WLxWL multiplier core among NREQ requesters, products routed back by tag.
// Latency: grant at t -> rsp_valid at t+1+LAT, or t+2+LAT with MULT_ARB_OUTREG_EN (registered outputs).
// Backpressure: one grant per cycle through req_ready; responses cannot be stalled and must be taken.
module mult_share_arb #(
   parameter int WL   = 9,
   parameter int NREQ = 4,
   parameter int LAT  = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   mult_share_arb_if.slave bus
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef struct packed {
      logic           vld;
      logic [IDW-1:0] id;
   } tag_t;

   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [WL-1:0]   mult_a_q, mult_a_d;
   logic [WL-1:0]   mult_b_q, mult_b_d;
   tag_t [LAT:0]    tag_q, tag_d;
   logic            gnt_found;
   logic [IDW-1:0]  gnt_id;
   logic            xfer;
   logic            in_flight;
   logic [NREQ-1:0] last_dec;

   function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return IDW'(s);
   endfunction

   // First valid requester at or after ptr wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int off = 0; off < NREQ; off++) begin
         if (!gnt_found && bus.req_valid[wrap_idx(ptr_q, off)]) begin
            gnt_found = 1'b1;
            gnt_id    = wrap_idx(ptr_q, off);
         end
      end
   end

   assign xfer = gnt_found & rst_n;

   always_comb begin
      bus.req_ready = '0;
      if (xfer) bus.req_ready[gnt_id] = 1'b1;
   end

   always_comb begin
      ptr_d    = ptr_q;
      mult_a_d = mult_a_q;
      mult_b_d = mult_b_q;
      if (xfer) begin
         ptr_d    = wrap_idx(gnt_id, 1);
         mult_a_d = bus.req_a[gnt_id*WL +: WL];
         mult_b_d = bus.req_b[gnt_id*WL +: WL];
      end
      tag_d[0].vld = xfer;
      tag_d[0].id  = gnt_id;
      for (int i = 1; i <= LAT; i++) tag_d[i] = tag_q[i-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= '0;
         mult_a_q <= '0;
         mult_b_q <= '0;
         tag_q    <= '0;
      end else begin
         ptr_q    <= ptr_d;
         mult_a_q <= mult_a_d;
         mult_b_q <= mult_b_d;
         tag_q    <= tag_d;
      end
   end

   // The last tag stage lines up with the core output.
   always_comb begin
      in_flight = 1'b0;
      for (int i = 0; i <= LAT; i++) in_flight = in_flight | tag_q[i].vld;
      last_dec = '0;
      if (tag_q[LAT].vld) last_dec[tag_q[LAT].id] = 1'b1;
   end

   assign bus.mult_a = mult_a_q;
   assign bus.mult_b = mult_b_q;

`ifdef MULT_ARB_OUTREG_EN
   logic [NREQ-1:0] rsp_vld_q, rsp_vld_d;
   logic [2*WL-1:0] rsp_p_q, rsp_p_d;

   always_comb begin
      rsp_vld_d = last_dec;
      rsp_p_d   = tag_q[LAT].vld ? bus.mult_p : rsp_p_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_vld_q <= '0;
         rsp_p_q   <= '0;
      end else begin
         rsp_vld_q <= rsp_vld_d;
         rsp_p_q   <= rsp_p_d;
      end
   end

   assign bus.rsp_valid = rsp_vld_q;
   assign bus.rsp_p     = rsp_p_q;
   assign bus.idle      = ~in_flight & ~(|rsp_vld_q);
`else
   assign bus.rsp_valid = last_dec;
   assign bus.rsp_p     = rst_n ? bus.mult_p : '0;
   assign bus.idle      = ~in_flight;
`endif
endmodule
